baud_gen_frac: RTL and testbench

//  Parametrised fractional baud-tick generator for the UART path.
//  - One instance per direction: TX uses bit_tick; RX uses os_tick, mid_tick and resync.
//  - Divisor is runtime-loadable: integer part plus FRAC_W-bit fraction.
//  - Produces an OVERSAMPLE-times oversample tick, a bit tick and a mid-bit tick.

---
 rtl/baud_gen_frac.sv | 134 +++++++++++++
 tb/tb_baud_gen_frac.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/baud_gen_frac.sv
// Fractional baud-tick generator: OVERSAMPLE-rate tick plus bit and mid-bit ticks,
// with a runtime-loadable integer+fraction divisor applied only at period boundaries.
module baud_gen_frac #(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned FRAC_W     = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [DIV_W-1:0]  div_int_i,
    input  logic [FRAC_W-1:0] div_frac_i,
    input  logic              div_load_i,
    input  logic              resync_i,
    output logic              os_tick_o,
    output logic              bit_tick_o,
    output logic              mid_tick_o,
    output logic              busy_div_o
);

    localparam int unsigned CNT_W = DIV_W + 1;
    localparam int unsigned PH_W  = $clog2(OVERSAMPLE);

    // Reset divisor: whole clocks per os_tick plus the rounded fraction.
    localparam longint unsigned TICK_HZ = 64'(BAUD_RATE) * 64'(OVERSAMPLE);
    localparam longint unsigned REM0    = 64'(CLK_FREQ) % TICK_HZ;
    localparam longint unsigned FRAC0_R = ((REM0 << FRAC_W) + TICK_HZ / 64'd2) / TICK_HZ;
    localparam logic [DIV_W-1:0]  DIV0  = DIV_W'(64'(CLK_FREQ) / TICK_HZ);
    localparam logic [FRAC_W-1:0] FRAC0 = FRAC_W'(FRAC0_R);

    localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);
    localparam logic [PH_W-1:0] PH_MID  = PH_W'(OVERSAMPLE / 2 - 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic [DIV_W-1:0]  int_act_q, int_act_d, int_sh_q, int_sh_d;
    logic [FRAC_W-1:0] frac_act_q, frac_act_d, frac_sh_q, frac_sh_d;
    logic              busy_q, busy_d;
    logic              os_q, os_d, bit_q, bit_d, mid_q, mid_d;

    logic [FRAC_W:0]   acc_sum;
    logic [CNT_W-1:0]  period;
    logic              wrap;
    logic              boundary;

    // Period length is fixed for the whole count: acc and the active divisor only move at boundaries.
    assign acc_sum  = {1'b0, acc_q} + {1'b0, frac_act_q};
    assign period   = ((int_act_q == '0) ? CNT_W'(1) : {1'b0, int_act_q}) + CNT_W'(acc_sum[FRAC_W]);
    assign wrap     = (cnt_q == period - CNT_W'(1));
    assign boundary = !en_i || resync_i || wrap;

    always_comb begin
        cnt_d      = cnt_q;
        phase_d    = phase_q;
        acc_d      = acc_q;
        int_act_d  = int_act_q;
        frac_act_d = frac_act_q;
        int_sh_d   = int_sh_q;
        frac_sh_d  = frac_sh_q;
        busy_d     = busy_q;
        os_d       = 1'b0;
        bit_d      = 1'b0;
        mid_d      = 1'b0;

        if (!en_i || resync_i) begin
            cnt_d   = '0;
            phase_d = '0;
            acc_d   = '0;
        end else if (wrap) begin
            cnt_d   = '0;
            acc_d   = acc_sum[FRAC_W-1:0];
            phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
            os_d    = 1'b1;
            bit_d   = (phase_q == PH_LAST);
            mid_d   = (phase_q == PH_MID);
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // A load landing on a boundary goes straight to the active divisor.
        if (div_load_i) begin
            int_sh_d  = div_int_i;
            frac_sh_d = div_frac_i;
            if (boundary) begin
                int_act_d  = div_int_i;
                frac_act_d = div_frac_i;
                busy_d     = 1'b0;
            end else begin
                busy_d = 1'b1;
            end
        end else if (busy_q && boundary) begin
            int_act_d  = int_sh_q;
            frac_act_d = frac_sh_q;
            busy_d     = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            phase_q    <= '0;
            acc_q      <= '0;
            int_act_q  <= DIV0;
            frac_act_q <= FRAC0;
            int_sh_q   <= DIV0;
            frac_sh_q  <= FRAC0;
            busy_q     <= 1'b0;
            os_q       <= 1'b0;
            bit_q      <= 1'b0;
            mid_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            acc_q      <= acc_d;
            int_act_q  <= int_act_d;
            frac_act_q <= frac_act_d;
            int_sh_q   <= int_sh_d;
            frac_sh_q  <= frac_sh_d;
            busy_q     <= busy_d;
            os_q       <= os_d;
            bit_q      <= bit_d;
            mid_q      <= mid_d;
        end
    end

    assign os_tick_o  = os_q;
    assign bit_tick_o = bit_q;
    assign mid_tick_o = mid_q;
    assign busy_div_o = busy_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Bench for baud_gen_frac: closed-form tick-time model checked every cycle,
// plus directed scenarios with hand-computed tick positions.
module tb_baud_gen_frac;

    localparam int CLK_FREQ   = 50000000;
    localparam int BAUD_RATE  = 115200;
    localparam int OS         = 16;
    localparam int DIV_W      = 16;
    localparam int FRAC_W     = 4;
    localparam int FS         = 1 << FRAC_W;
    localparam int TICK_HZ    = BAUD_RATE * OS;
    localparam int DIV0       = CLK_FREQ / TICK_HZ;
    localparam int FRAC0      = ((CLK_FREQ % TICK_HZ) * FS + TICK_HZ / 2) / TICK_HZ;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [DIV_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic              div_load;
    logic              resync;
    logic              os_tick, bit_tick, mid_tick, busy_div;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    baud_gen_frac #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE),
        .OVERSAMPLE(OS),
        .DIV_W     (DIV_W),
        .FRAC_W    (FRAC_W)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .en_i      (en),
        .div_int_i (div_int),
        .div_frac_i(div_frac),
        .div_load_i(div_load),
        .resync_i  (resync),
        .os_tick_o (os_tick),
        .bit_tick_o(bit_tick),
        .mid_tick_o(mid_tick),
        .busy_div_o(busy_div)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: since the last restart (base acc a, divisor I.F), tick k lands
    // k*I + floor((a + k*F)/2^FRAC_W) edges after the base.
    int m_i, m_f, s_i, s_f, m_el, m_k, m_a, m_ph;
    bit m_pend;
    logic exp_os = 1'b0, exp_bit = 1'b0, exp_mid = 1'b0, exp_busy = 1'b0;

    always @(posedge clk or posedge rst) begin
        int ieff, nxt;
        bit tick, restart, bound;
        if (rst) begin
            m_i = DIV0; m_f = FRAC0; s_i = DIV0; s_f = FRAC0; m_pend = 0;
            m_el = 0; m_k = 0; m_a = 0; m_ph = 0;
            exp_os = 0; exp_bit = 0; exp_mid = 0; exp_busy = 0;
        end else begin
            ieff    = (m_i == 0) ? 1 : m_i;
            nxt     = (m_k + 1) * ieff + (m_a + (m_k + 1) * m_f) / FS;
            restart = !en || resync;
            tick    = !restart && (m_el + 1 == nxt);
            bound   = restart || tick;
            exp_os = 0; exp_bit = 0; exp_mid = 0;
            if (restart) begin
                m_el = 0; m_k = 0; m_a = 0; m_ph = 0;
            end else if (tick) begin
                exp_os  = 1;
                exp_bit = (m_ph == OS - 1);
                exp_mid = (m_ph == OS / 2 - 1);
                m_ph    = (m_ph + 1) % OS;
                m_k++;
                m_el++;
            end else begin
                m_el++;
            end
            if (bound && (div_load || m_pend)) begin
                if (!restart) begin
                    m_a = (m_a + m_k * m_f) % FS;
                    m_el = 0; m_k = 0;
                end
                m_i = div_load ? int'(div_int) : s_i;
                m_f = div_load ? int'(div_frac) : s_f;
                m_pend = 0;
                if (div_load) begin s_i = int'(div_int); s_f = int'(div_frac); end
            end else if (div_load) begin
                s_i = int'(div_int); s_f = int'(div_frac); m_pend = 1;
            end
            exp_busy = m_pend;
        end
    end

    always @(negedge clk) begin
        chk("os_tick",  int'(os_tick),  int'(exp_os));
        chk("bit_tick", int'(bit_tick), int'(exp_bit));
        chk("mid_tick", int'(mid_tick), int'(exp_mid));
        chk("busy_div", int'(busy_div), int'(exp_busy));
    end

    int q_os[$], q_bit[$], q_mid[$];
    int n_busy;

    task automatic capture(input int n);
        q_os.delete(); q_bit.delete(); q_mid.delete(); n_busy = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (os_tick)  q_os.push_back(cyc);
            if (bit_tick) q_bit.push_back(cyc);
            if (mid_tick) q_mid.push_back(cyc);
            if (busy_div) n_busy++;
        end
    endtask

    function automatic int qat(input int q[$], input int i);
        if (i >= 0 && i < q.size()) return q[i];
        return -100000;
    endfunction

    task automatic wait_os(output int at);
        at = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (os_tick) begin
                at = cyc;
                break;
            end
        end
    endtask

    // Release reset with en=1 at reset defaults (27 + 2/16).
    task automatic run_defaults(input string p);
        int c0, n28;
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;
        c0  = cyc;
        capture(880);
        chk({p, "_first_os"},  qat(q_os, 0) - c0, 27);
        chk({p, "_os_gap0"},   qat(q_os, 1) - qat(q_os, 0), 27);
        chk({p, "_first_mid"}, qat(q_mid, 0) - c0, 217);
        chk({p, "_first_bit"}, qat(q_bit, 0) - c0, 434);
        chk({p, "_bit_gap"},   qat(q_bit, 1) - qat(q_bit, 0), 434);
        chk({p, "_n_os"},      q_os.size(), 32);
        n28 = 0;
        for (int i = 16; i <= 31; i++)
            if (qat(q_os, i) - qat(q_os, i - 1) == 28) n28++;
        chk({p, "_n28"}, n28, 2);
    endtask

    initial begin
        int c0, t, r;
        rst = 1'b0; en = 1'b0; resync = 1'b0; div_load = 1'b0;
        div_int = '0; div_frac = '0;
        #1 rst = 1'b1;
        @(negedge clk);
        chk("reset_os",   int'(os_tick), 0);
        chk("reset_busy", int'(busy_div), 0);

        run_defaults("s1");

        // div 4.0 loaded while idle takes effect immediately
        @(negedge clk);
        en = 1'b0; div_int = 16'd4; div_frac = 4'd0; div_load = 1'b1;
        @(negedge clk);
        div_load = 1'b0; en = 1'b1; c0 = cyc;
        capture(140);
        chk("s2_first_os", qat(q_os, 0) - c0, 4);
        chk("s2_os_gap",   qat(q_os, 1) - qat(q_os, 0), 4);
        chk("s2_mid",      qat(q_mid, 0) - c0, 32);
        chk("s2_bit",      qat(q_bit, 0) - c0, 64);
        chk("s2_bit_gap",  qat(q_bit, 1) - qat(q_bit, 0), 64);
        chk("s2_busy",     n_busy, 0);

        // resync one clock after a tick
        @(negedge clk);
        resync = 1'b1; r = cyc + 1;
        @(negedge clk);
        resync = 1'b0;
        capture(70);
        chk("s4_first_os", qat(q_os, 0) - r, 4);
        chk("s4_n_mid",    q_mid.size(), 1);
        chk("s4_mid",      qat(q_mid, 0) - r, 32);
        chk("s4_n_bit",    q_bit.size(), 1);
        chk("s4_bit",      qat(q_bit, 0) - r, 64);

        // load 10 one clock into a 4-clock period
        wait_os(t);
        chk("s3_sync", int'(t >= 0), 1);
        div_int = 16'd10; div_load = 1'b1;
        @(negedge clk);
        div_load = 1'b0;
        c0 = busy_div ? 1 : 0;
        capture(20);
        chk("s3_busy_len", n_busy + c0, 3);
        chk("s3_old_len",  qat(q_os, 0) - t, 4);
        chk("s3_new_len",  qat(q_os, 1) - qat(q_os, 0), 10);

        // en low for 7 clocks
        @(negedge clk);
        en = 1'b0;
        capture(7);
        chk("s5_no_os", q_os.size(), 0);
        en = 1'b1; c0 = cyc;
        capture(90);
        chk("s5_first_os", qat(q_os, 0) - c0, 10);
        chk("s5_mid",      qat(q_mid, 0) - c0, 80);

        // div_int=0 behaves as 1
        @(negedge clk);
        en = 1'b0; div_int = 16'd0; div_frac = 4'd0; div_load = 1'b1;
        @(negedge clk);
        div_load = 1'b0; en = 1'b1; c0 = cyc;
        capture(6);
        chk("s7_n_os",     q_os.size(), 6);
        chk("s7_first_os", qat(q_os, 0) - c0, 1);

        // async reset between clock edges
        wait_os(t);
        chk("s6_os_high", int'(os_tick), 1);
        #2 rst = 1'b1;
        #1;
        chk("s6_async_os",   int'(os_tick), 0);
        chk("s6_async_bit",  int'(bit_tick), 0);
        chk("s6_async_mid",  int'(mid_tick), 0);
        chk("s6_async_busy", int'(busy_div), 0);
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        run_defaults("s6");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
